// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, single-outstanding memory port, {pc, instr} FIFO
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        state_q;
  logic          mem_req_q;
  logic [31:0]   addr_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q    [FIFO_DEPTH];
  logic [31:0]   instr_mem_q [FIFO_DEPTH];

  logic          ack_hit;
  logic          push;
  logic          pop;
  logic          space_d;
  logic [31:0]   redirect_target;

  // An ack only counts while a request is actually on the bus.
  assign ack_hit         = mem_req_q & mem_ack_i;
  // Only acks for the live (non-discarded) request produce data; redirect kills same-edge push/pop.
  assign push            = (state_q == REQ) & ack_hit & ~redirect_i;
  assign pop             = instr_valid_o & instr_ready_i & ~redirect_i;
  assign redirect_target = {redirect_pc_i[31:2], 2'b00};
  assign space_d         = (count_d < DEPTH_C);

  // FIFO occupancy, pointers and fetch PC for the coming edge; redirect flushes everything.
  always_comb begin
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_target;
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end
  end

  // Fetch FSM with registered request/address; a request is only raised when a FIFO slot is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      addr_q    <= RESET_VECTOR;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect_i || space_d) begin
            state_q   <= REQ;
            mem_req_q <= 1'b1;
          end
          addr_q <= fetch_pc_d;
        end
        REQ: begin
          if (ack_hit) begin
            if (redirect_i || space_d) begin
              state_q   <= REQ;
              mem_req_q <= 1'b1;
            end else begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
            end
            addr_q <= fetch_pc_d;
          end else if (redirect_i) begin
            // Outstanding request must still complete; its data will be dropped.
            state_q <= DISCARD;
          end
        end
        DISCARD: begin
          if (ack_hit) begin
            state_q   <= REQ;
            mem_req_q <= 1'b1;
            addr_q    <= fetch_pc_d;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          addr_q    <= fetch_pc_d;
        end
      endcase
    end
  end

  // FIFO bookkeeping and fetch PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_VECTOR;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= mem_rdata_i;
    end
  end

  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = addr_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign instr_pc_o    = instr_valid_o ? pc_mem_q[rd_ptr_q]    : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based reference model
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  fetch_unit #(.RESET_VECTOR(32'h00000000), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          disc;
  logic [31:0] exp_pc;
  int          lat;
  int          wait_cnt;
  bit          rand_mode;
  logic [31:0] key;
  bit          stall_prev;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    disc       = 1'b0;
    exp_pc     = 32'h0;
    stall_prev = 1'b0;
    wait_cnt   = 0;
  endtask

  // One clock: drive memory, snapshot pre-edge bus, advance model, compare after the edge.
  task automatic cycle();
    logic        p_req, p_ack, p_ready, p_red, p_rst;
    logic [31:0] p_addr, p_rdata, p_rpc;
    bit          stall_now;
    if (mem_req_o) mem_ack_i = (wait_cnt >= lat);
    else           mem_ack_i = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
    mem_rdata_i = mem_ack_i ? (mem_addr_o ^ key) : $urandom;
    p_req = mem_req_o;  p_ack = mem_ack_i;  p_addr = mem_addr_o;  p_rdata = mem_rdata_i;
    p_ready = instr_ready_i;  p_red = redirect_i;  p_rpc = redirect_pc_i;  p_rst = rst_n;
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
    if (!rst_n) begin
      model_clear();
    end else begin
      if (p_red) begin
        q.delete();
        disc   = p_req && !p_ack;
        exp_pc = {p_rpc[31:2], 2'b00};
      end else begin
        if (p_ready && q.size() > 0) void'(q.pop_front());
        if (p_req && p_ack) begin
          if (disc) disc = 1'b0;
          else begin
            chk_eq("fetch_order", p_addr, exp_pc);
            q.push_back('{pc: p_addr, d: p_rdata});
            exp_pc = exp_pc + 32'd4;
          end
        end
      end
      if (p_req && p_ack) begin
        wait_cnt = 0;
        if (rand_mode) lat = $urandom_range(0, 3);
      end else if (p_req) begin
        wait_cnt++;
      end
    end
    chk_eq("valid", instr_valid_o, q.size() != 0);
    if (q.size() != 0) begin
      chk_eq("instr_pc", instr_pc_o, q[0].pc);
      chk_eq("instr", instr_o, q[0].d);
    end else begin
      chk_eq("instr_pc_idle", instr_pc_o, 32'h0);
      chk_eq("instr_idle", instr_o, 32'h0);
    end
    chk_eq("addr_align", mem_addr_o[1:0], 2'b00);
    if (!rst_n) begin
      chk_eq("rst_req", mem_req_o, 1'b0);
      chk_eq("rst_addr", mem_addr_o, 32'h0);
    end else begin
      if (mem_req_o) chk_eq("req_has_space", q.size() < DEPTH, 1'b1);
      if (p_rst && p_req && !p_ack) begin
        chk_eq("req_held", mem_req_o, 1'b1);
        chk_eq("addr_stable", mem_addr_o, p_addr);
      end
      stall_now = !mem_req_o && (q.size() < DEPTH);
      if (stall_prev) chk_eq("no_stall", stall_now, 1'b0);
      stall_prev = stall_now;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;  mem_ack_i = 1'b0;  mem_rdata_i = 32'h0;
    redirect_i = 1'b0;  redirect_pc_i = 32'h0;  instr_ready_i = 1'b1;
    rand_mode = 1'b0;  key = 32'h0;  lat = 0;
    model_clear();
    @(posedge clk);
    #1;

    // Zero-wait stream: first valid two edges after release, then 0,4,8.
    instr_ready_i = 1'b1;  lat = 0;
    do_reset();
    cycle();
    chk_eq("t1_e1_valid", instr_valid_o, 1'b0);
    chk_eq("t1_e1_req", mem_req_o, 1'b1);
    chk_eq("t1_e1_addr", mem_addr_o, 32'h0);
    cycle();
    chk_eq("t1_e2_valid", instr_valid_o, 1'b1);
    chk_eq("t1_e2_pc", instr_pc_o, 32'h0);
    cycle();
    chk_eq("t1_e3_pc", instr_pc_o, 32'h4);
    cycle();
    chk_eq("t1_e4_pc", instr_pc_o, 32'h8);
    chk_eq("t1_e4_instr", instr_o, 32'h8);

    // Back-pressure: two entries buffered, request drops, one pop reopens fetch at 8.
    instr_ready_i = 1'b0;
    do_reset();
    cycle();
    cycle();
    cycle();
    chk_eq("t2_full_req", mem_req_o, 1'b0);
    chk_eq("t2_full_pc", instr_pc_o, 32'h0);
    cycle();
    chk_eq("t2_idle_req", mem_req_o, 1'b0);
    instr_ready_i = 1'b1;
    cycle();
    instr_ready_i = 1'b0;
    chk_eq("t2_pop_req", mem_req_o, 1'b1);
    chk_eq("t2_pop_addr", mem_addr_o, 32'h8);
    chk_eq("t2_pop_pc", instr_pc_o, 32'h4);
    cycle();
    chk_eq("t2_refill_req", mem_req_o, 1'b0);

    // Three-cycle memory: one instruction every three edges.
    instr_ready_i = 1'b1;  lat = 2;
    do_reset();
    repeat (4) cycle();
    chk_eq("t3_first_valid", instr_valid_o, 1'b1);
    chk_eq("t3_first_pc", instr_pc_o, 32'h0);
    cycle();
    chk_eq("t3_gap_valid", instr_valid_o, 1'b0);
    chk_eq("t3_gap_addr", mem_addr_o, 32'h4);
    cycle();
    chk_eq("t3_gap2_valid", instr_valid_o, 1'b0);
    cycle();
    chk_eq("t3_second_pc", instr_pc_o, 32'h4);

    // Redirect while the request to 0x10 is outstanding.
    lat = 0;
    do_reset();
    for (int i = 0; i < 20 && mem_addr_o !== 32'h10; i++) cycle();
    chk_eq("t4_reach_10", mem_addr_o, 32'h10);
    lat = 3;
    redirect_i = 1'b1;  redirect_pc_i = 32'h00000103;
    cycle();
    chk_eq("t4_flush_valid", instr_valid_o, 1'b0);
    chk_eq("t4_discard_req", mem_req_o, 1'b1);
    chk_eq("t4_discard_addr", mem_addr_o, 32'h10);
    for (int i = 0; i < 10 && mem_addr_o !== 32'h100; i++) cycle();
    chk_eq("t4_new_addr", mem_addr_o, 32'h100);
    lat = 0;
    for (int i = 0; i < 5 && instr_valid_o !== 1'b1; i++) cycle();
    chk_eq("t4_first_pc", instr_pc_o, 32'h100);

    // Redirect on the same edge as ack and pop with one buffered entry.
    cycle();
    cycle();
    chk_eq("t5_one_entry", instr_valid_o, 1'b1);
    redirect_i = 1'b1;  redirect_pc_i = 32'h00002000;
    cycle();
    chk_eq("t5_valid", instr_valid_o, 1'b0);
    chk_eq("t5_req", mem_req_o, 1'b1);
    chk_eq("t5_addr", mem_addr_o, 32'h2000);

    // Address wrap, then asynchronous reset mid-wait.
    redirect_i = 1'b1;  redirect_pc_i = 32'hFFFFFFF8;
    cycle();
    chk_eq("t6_addr", mem_addr_o, 32'hFFFFFFF8);
    cycle();
    chk_eq("t6_pc0", instr_pc_o, 32'hFFFFFFF8);
    cycle();
    chk_eq("t6_pc1", instr_pc_o, 32'hFFFFFFFC);
    cycle();
    chk_eq("t6_pc2", instr_pc_o, 32'h00000000);
    lat = 5;
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("t6_arst_req", mem_req_o, 1'b0);
    chk_eq("t6_arst_addr", mem_addr_o, 32'h0);
    chk_eq("t6_arst_valid", instr_valid_o, 1'b0);
    chk_eq("t6_arst_instr", instr_o, 32'h0);
    chk_eq("t6_arst_pc", instr_pc_o, 32'h0);
    model_clear();
    cycle();

    // Randomized traffic: variable latency, back-pressure, stray acks, redirects.
    rand_mode = 1'b1;  lat = 1;  key = $urandom;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      instr_ready_i = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 31) == 0) begin
        redirect_i    = 1'b1;
        redirect_pc_i = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                                    : $urandom;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of the decoder and immediate generator and feeds them instruction words.
- Owns the program counter and issues word reads on a single-outstanding req/ack memory port.
- Buffers returned words with their PC in a small FIFO and presents them on a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from execute, which flush all in-flight and buffered fetches.

Parameters:
- RESET_VECTOR, 32'h00000000, first fetch address after reset.
- FIFO_DEPTH, 2, number of buffered {pc, instr} entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_req_o  out  1  read request; held high until acknowledged.
- mem_addr_o  out  32  word-aligned fetch address; stable while mem_req_o is high and unacknowledged.
- mem_ack_i  in  1  read complete; may arrive in the same cycle as mem_req_o rises.
- mem_rdata_i  in  32  instruction word; valid only when mem_ack_i is high.
- redirect_i  in  1  one-cycle pulse: flush and restart fetch.
- redirect_pc_i  in  32  new fetch address; bits [1:0] ignored and forced to 0.
- instr_valid_o  out  1  FIFO head valid.
- instr_o  out  32  head instruction; 32'h0 when not valid.
- instr_pc_o  out  32  PC of head instruction; 32'h0 when not valid.
- instr_ready_i  in  1  consumer accepts head when high together with instr_valid_o.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, fetch_pc=RESET_VECTOR, FIFO count=0, mem_req_o=0, mem_addr_o=RESET_VECTOR, instr_valid_o=0, instr_o=0, instr_pc_o=0.
- FSM states: IDLE, REQ, DISCARD.
  - IDLE: mem_req_o=0. Moves to REQ on the next edge when FIFO has space (count_next < FIFO_DEPTH). The first edge after reset release always goes to REQ.
  - REQ: mem_req_o=1, mem_addr_o=fetch_pc.
    - On an edge with mem_ack_i=1: push {fetch_pc, mem_rdata_i} and set fetch_pc += 4 (mod 2^32; 32'hFFFFFFFC wraps to 0).
    - After the ack: stay in REQ if count_next < FIFO_DEPTH, else go to IDLE.
    - No ack: hold address, stay in REQ.
  - DISCARD: mem_req_o=1, mem_addr_o = stale address. On ack, drop the data and go to REQ (fetch_pc already holds the redirect target).
- Ack is honoured only when mem_req_o=1; mem_ack_i in IDLE is ignored.
- Zero-wait memory (ack every cycle) plus ready always high sustains 1 instruction/cycle; mem_req_o stays high back-to-back.
- Latency:
  - Data acked at edge N gives instr_valid_o high after edge N; the FIFO is registered with no bypass.
  - First valid after reset release is 2 edges later with zero-wait memory.
- FIFO:
  - instr_valid_o = (count != 0); outputs reflect the head entry.
  - Pop on edge where instr_valid_o & instr_ready_i. Push and pop on the same edge are allowed; count is unchanged.
  - Never overflows: no request is issued unless space is guaranteed. Pop while empty is a no-op.
- Redirect (redirect_i=1 at an edge) has highest priority:
  - FIFO is flushed (count=0) and fetch_pc = {redirect_pc_i[31:2], 2'b00}. Any same-edge pop or push is discarded.
  - From REQ with no ack this edge: go to DISCARD; the outstanding request must complete.
  - From REQ with ack this edge, or from IDLE: go to REQ with the new address next cycle.
  - From DISCARD: stay in DISCARD, with fetch_pc updated to the newest target.
  - instr_valid_o is 0 in the cycle after a redirect.
- Reset asserted mid-transaction returns to reset values immediately. The memory side must tolerate an abandoned request.
- Misaligned RESET_VECTOR is not supported; behaviour is undefined.

Test Plan:
- Reset release, ack tied high, ready high, memory returns addr as data -> instr_pc_o/instr_o = 0,4,8,... on consecutive cycles; first valid 2 edges after release.
- ready held low, zero-wait memory -> exactly 2 entries buffered (pc 0,4), mem_req_o drops; ready high 1 cycle -> pc 0 popped, one new request for pc 8 issued.
- Memory with 3-cycle ack latency -> mem_addr_o stable during wait; one instruction every 3 cycles; no duplicates or skips.
- redirect_i with redirect_pc_i=32'h00000103 while request to 0x10 is outstanding -> FIFO flushed, DISCARD until ack, 0x10 data never appears, next fetch addr 0x100, first valid pc 0x100.
- redirect_i on the same edge as ack and pop, FIFO holding 1 entry -> count=0, no valid next cycle, next mem_addr_o = redirect target.
- Fetch from 32'hFFFFFFF8 sequentially -> pcs FFFFFFF8, FFFFFFFC, 00000000; async rst_n pulse mid-wait -> outputs return to reset values immediately.
